// File: rtl/axi_reg_slice_pkg.sv
// Payload types shared by the 512-bit AXI register slice and its skid buffers.
package axi_reg_slice_pkg;

  localparam int AXI_ID_W   = 16;
  localparam int AXI_ADDR_W = 64;
  localparam int AXI_DATA_W = 512;
  localparam int AXI_STRB_W = 64;

  // Address-channel payload; AR reuses this type.
  typedef struct packed {
    logic [AXI_ID_W-1:0]   id;
    logic [AXI_ADDR_W-1:0] addr;
    logic [7:0]            len;
    logic [2:0]            size;
  } axi_aw_t;

  typedef struct packed {
    logic [AXI_DATA_W-1:0] data;
    logic [AXI_STRB_W-1:0] strb;
    logic                  last;
    logic                  user;
  } axi_w_t;

  typedef struct packed {
    logic [AXI_ID_W-1:0] id;
    logic [1:0]          resp;
  } axi_b_t;

  typedef struct packed {
    logic [AXI_ID_W-1:0]   id;
    logic [AXI_DATA_W-1:0] data;
    logic [1:0]            resp;
    logic                  last;
    logic                  user;
  } axi_r_t;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_FULL  = 2'd2
  } skid_state_t;

endpackage

// File: rtl/axi_reg_slice_bus.sv
// AXI bus bundle. Modports are named after the agent each slice port faces:
// "master" accepts AW/W/AR and returns B/R, "slave" issues AW/W/AR and accepts B/R.
interface axi_bus_t;
  import axi_reg_slice_pkg::*;

  logic    awvalid, awready;
  axi_aw_t aw;
  logic    wvalid, wready;
  axi_w_t  w;
  logic    bvalid, bready;
  axi_b_t  b;
  logic    arvalid, arready;
  axi_aw_t ar;
  logic    rvalid, rready;
  axi_r_t  r;

  modport master (
    input  awvalid, aw, wvalid, w, arvalid, ar, bready, rready,
    output awready, wready, arready, bvalid, b, rvalid, r
  );

  modport slave (
    output awvalid, aw, wvalid, w, arvalid, ar, bready, rready,
    input  awready, wready, arready, bvalid, b, rvalid, r
  );

endinterface

// File: rtl/axi_skid_buf.sv
// Two-entry skid buffer: both in_ready and out_valid come straight from flops,
// so no valid/ready path crosses the buffer combinationally.
module axi_skid_buf
  import axi_reg_slice_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  skid_state_t      state, state_nxt;
  logic [WIDTH-1:0] main_q, skid_q;
  logic             in_ready_q, out_valid_q;
  logic             push, pop;
  logic             load_main_in, load_main_skid, load_skid;

  assign push = in_valid & in_ready_q;
  assign pop  = out_valid_q & out_ready;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_nxt      = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    unique case (state)
      SKID_EMPTY: if (push) begin
        state_nxt    = SKID_ONE;
        load_main_in = 1'b1;
      end
      SKID_ONE: begin
        if (push && pop) begin
          load_main_in = 1'b1;
        end else if (push) begin
          state_nxt = SKID_FULL;
          load_skid = 1'b1;
        end else if (pop) begin
          state_nxt = SKID_EMPTY;
        end
      end
      SKID_FULL: if (pop) begin
        state_nxt      = SKID_ONE;
        load_main_skid = 1'b1;
      end
      default: state_nxt = SKID_EMPTY;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= SKID_EMPTY;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state       <= state_nxt;
      in_ready_q  <= (state_nxt != SKID_FULL);
      out_valid_q <= (state_nxt != SKID_EMPTY);
    end
  end

  // NOTE: payload regs are reset too, so a freshly reset slice never presents stale data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main_in)        main_q <= in_data;
      else if (load_main_skid) main_q <= skid_q;
      if (load_skid)           skid_q <= in_data;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_q;

endmodule

// File: rtl/axi_reg_slice.sv
// Full-throughput AXI register slice: one skid buffer per channel, each channel
// individually replaceable by a combinational wire-through.
module axi_reg_slice
  import axi_reg_slice_pkg::*;
#(
  parameter bit REG_AW = 1'b1,
  parameter bit REG_W  = 1'b1,
  parameter bit REG_B  = 1'b1,
  parameter bit REG_AR = 1'b1,
  parameter bit REG_R  = 1'b1
) (
  input  logic     clk,
  input  logic     rst,
  axi_bus_t.master up,
  axi_bus_t.slave  down
);

  if (REG_AW) begin : g_aw
    axi_skid_buf #(.WIDTH($bits(axi_aw_t))) u_buf (
      .clk(clk), .rst(rst),
      .in_valid(up.awvalid),    .in_ready(up.awready),   .in_data(up.aw),
      .out_valid(down.awvalid), .out_ready(down.awready), .out_data(down.aw)
    );
  end else begin : g_aw_wire
    assign down.awvalid = up.awvalid;
    assign down.aw      = up.aw;
    assign up.awready   = down.awready;
  end

  if (REG_W) begin : g_w
    axi_skid_buf #(.WIDTH($bits(axi_w_t))) u_buf (
      .clk(clk), .rst(rst),
      .in_valid(up.wvalid),    .in_ready(up.wready),   .in_data(up.w),
      .out_valid(down.wvalid), .out_ready(down.wready), .out_data(down.w)
    );
  end else begin : g_w_wire
    assign down.wvalid = up.wvalid;
    assign down.w      = up.w;
    assign up.wready   = down.wready;
  end

  // B and R flow from the downstream side back to the upstream side.
  if (REG_B) begin : g_b
    axi_skid_buf #(.WIDTH($bits(axi_b_t))) u_buf (
      .clk(clk), .rst(rst),
      .in_valid(down.bvalid), .in_ready(down.bready), .in_data(down.b),
      .out_valid(up.bvalid),  .out_ready(up.bready),  .out_data(up.b)
    );
  end else begin : g_b_wire
    assign up.bvalid   = down.bvalid;
    assign up.b        = down.b;
    assign down.bready = up.bready;
  end

  if (REG_AR) begin : g_ar
    axi_skid_buf #(.WIDTH($bits(axi_aw_t))) u_buf (
      .clk(clk), .rst(rst),
      .in_valid(up.arvalid),    .in_ready(up.arready),   .in_data(up.ar),
      .out_valid(down.arvalid), .out_ready(down.arready), .out_data(down.ar)
    );
  end else begin : g_ar_wire
    assign down.arvalid = up.arvalid;
    assign down.ar      = up.ar;
    assign up.arready   = down.arready;
  end

  if (REG_R) begin : g_r
    axi_skid_buf #(.WIDTH($bits(axi_r_t))) u_buf (
      .clk(clk), .rst(rst),
      .in_valid(down.rvalid), .in_ready(down.rready), .in_data(down.r),
      .out_valid(up.rvalid),  .out_ready(up.rready),  .out_data(up.r)
    );
  end else begin : g_r_wire
    assign up.rvalid   = down.rvalid;
    assign up.r        = down.r;
    assign down.rready = up.rready;
  end

endmodule
